// File: rtl/fft_frame_pkg.sv
// Shared types and width helpers for the FFT frame source and its stall buffer.
package fft_frame_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int DATA_W_DEF    = 15;
  localparam int FFT_LEN_DEF   = 1024;
  localparam int BUF_DEPTH_DEF = 8;
  localparam int FRM_W_DEF     = 16;

  // Index/occupancy width for a range of n values; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// Small register-array FIFO that absorbs downstream ready stalls; head entry is
// read straight from registers so the output side never sees the write data path.
module fft_frame_buf
  import fft_frame_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = BUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data
);

  localparam int AW = idx_w(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_data;
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fft_frame_source.sv
// Avalon-ST packet source: frames free-running ADC samples into FFT_LEN-sample
// packets for a commanded number of frames, with a small buffer to ride out backpressure.
module fft_frame_source
  import fft_frame_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FFT_LEN   = FFT_LEN_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int FRM_W     = FRM_W_DEF
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start,
  input  logic [FRM_W-1:0]  num_frames,
  input  logic              abort,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_startofpacket,
  output logic              out_endofpacket,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [FRM_W-1:0]  frames_sent
);

  localparam int              IDX_W    = idx_w(FFT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);

  state_t            state_q, state_d;
  logic [FRM_W-1:0]  num_frames_q, num_frames_d;
  logic [FRM_W-1:0]  in_frm_q, in_frm_d;
  logic [IDX_W-1:0]  in_idx_q, in_idx_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic [FRM_W-1:0]  frames_sent_q, frames_sent_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;

  logic              buf_push;
  logic              buf_pop;
  logic              buf_flush;
  logic              buf_full;
  logic              buf_empty;
  logic [DATA_W-1:0] buf_head;
  logic              in_active;
  logic              xfer;

  fft_frame_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (buf_push),
    .push_data (adc_data),
    .pop       (buf_pop),
    .flush     (buf_flush),
    .full      (buf_full),
    .empty     (buf_empty),
    .head_data (buf_head)
  );

  assign out_valid         = !buf_empty;
  assign out_data          = buf_head;
  assign out_startofpacket = out_valid && (out_idx_q == '0);
  assign out_endofpacket   = out_valid && (out_idx_q == LAST_IDX);
  assign busy              = (state_q == STREAM);
  assign done              = done_q;
  assign overflow          = overflow_q;
  assign frames_sent       = frames_sent_q;

  // in_idx < FFT_LEN always, so the sample budget is exhausted exactly when
  // in_frm reaches the commanded frame count.
  assign in_active = (in_frm_q < num_frames_q);
  assign xfer      = out_valid && out_ready;

  always_comb begin
    state_d       = state_q;
    num_frames_d  = num_frames_q;
    in_frm_d      = in_frm_q;
    in_idx_d      = in_idx_q;
    out_idx_d     = out_idx_q;
    frames_sent_d = frames_sent_q;
    overflow_d    = overflow_q;
    done_d        = 1'b0;
    buf_push      = 1'b0;
    buf_pop       = 1'b0;
    buf_flush     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (num_frames != '0) begin
            state_d       = STREAM;
            num_frames_d  = num_frames;
            in_frm_d      = '0;
            in_idx_d      = '0;
            out_idx_d     = '0;
            frames_sent_d = '0;
            overflow_d    = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      STREAM: begin
        if (abort) begin
          state_d   = IDLE;
          buf_flush = 1'b1;
        end else begin
          // Full is judged before any pop this cycle; a dropped sample is not
          // counted, so every packet still carries exactly FFT_LEN samples.
          if (adc_valid && in_active) begin
            if (buf_full) begin
              overflow_d = 1'b1;
            end else begin
              buf_push = 1'b1;
              if (in_idx_q == LAST_IDX) begin
                in_idx_d = '0;
                in_frm_d = in_frm_q + FRM_W'(1);
              end else begin
                in_idx_d = in_idx_q + IDX_W'(1);
              end
            end
          end

          if (xfer) begin
            buf_pop = 1'b1;
            if (out_idx_q == LAST_IDX) begin
              out_idx_d = '0;
              if (frames_sent_q != num_frames_q) begin
                frames_sent_d = frames_sent_q + FRM_W'(1);
              end
              if (frames_sent_q == num_frames_q - FRM_W'(1)) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end else begin
              out_idx_d = out_idx_q + IDX_W'(1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= IDLE;
      num_frames_q  <= '0;
      in_frm_q      <= '0;
      in_idx_q      <= '0;
      out_idx_q     <= '0;
      frames_sent_q <= '0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_frames_q  <= num_frames_d;
      in_frm_q      <= in_frm_d;
      in_idx_q      <= in_idx_d;
      out_idx_q     <= out_idx_d;
      frames_sent_q <= frames_sent_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_source.sv
// Directed bench for fft_frame_source with FFT_LEN=8, BUF_DEPTH=8 and a ramp ADC.
module tb_fft_frame_source;

  localparam int DW = 15;
  localparam int FL = 8;
  localparam int BD = 8;
  localparam int FW = 16;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n = 1'b0;
  logic          start = 1'b0;
  logic [FW-1:0] num_frames = '0;
  logic          abort = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_startofpacket;
  logic          out_endofpacket;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [FW-1:0] frames_sent;

  always #5 clk_clk = ~clk_clk;

  fft_frame_source #(
    .DATA_W    (DW),
    .FFT_LEN   (FL),
    .BUF_DEPTH (BD),
    .FRM_W     (FW)
  ) dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .start             (start),
    .num_frames        (num_frames),
    .abort             (abort),
    .adc_data          (adc_data),
    .adc_valid         (adc_valid),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .busy              (busy),
    .done              (done),
    .overflow          (overflow),
    .frames_sent       (frames_sent)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: records every transfer and checks hold-stability under stall.
  int            cyc = 0;
  int            done_cnt = 0;
  int            done_cyc = -1;
  int            last_xfer_cyc = -1;
  logic [31:0]   xd [$];
  logic          xs [$];
  logic          xe [$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_sop = 1'b0;
  logic          prev_eop = 1'b0;

  always @(negedge clk_clk) begin
    cyc++;
    if (!reset_reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("hold_valid", 32'(out_valid), 32'd1);
        check_val("hold_data", 32'(out_data), 32'(prev_data));
        check_val("hold_sop", 32'(out_startofpacket), 32'(prev_sop));
        check_val("hold_eop", 32'(out_endofpacket), 32'(prev_eop));
      end
      if (out_valid && out_ready) begin
        xd.push_back(32'(out_data));
        xs.push_back(out_startofpacket);
        xe.push_back(out_endofpacket);
        last_xfer_cyc = cyc;
        $display("xfer #%0d data=%0d sop=%0b eop=%0b frames_sent=%0d",
                 xd.size() - 1, out_data, out_startofpacket, out_endofpacket, frames_sent);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sop   = out_startofpacket;
      prev_eop   = out_endofpacket;
    end
  end

  // Start pulse at rel 0; ADC ramp sample value (base + rel - 1) from rel 1 on.
  // out_ready is low for rel in [s_rel, s_rel+s_len); abort pulses at abort_rel.
  task automatic run_stream(input int nfr, input int base, input int s_rel, input int s_len,
                            input int abort_rel, input int ncyc);
    xd.delete();
    xs.delete();
    xe.delete();
    done_cnt      = 0;
    done_cyc      = -1;
    last_xfer_cyc = -1;
    @(posedge clk_clk); #1;
    start      = 1'b1;
    num_frames = FW'(nfr);
    abort      = 1'b0;
    adc_valid  = 1'b0;
    out_ready  = 1'b1;
    for (int rel = 1; rel <= ncyc; rel++) begin
      @(posedge clk_clk); #1;
      start     = 1'b0;
      abort     = (rel == abort_rel);
      adc_valid = 1'b1;
      adc_data  = DW'(base + rel - 1);
      out_ready = !(rel >= s_rel && rel < s_rel + s_len);
    end
    @(posedge clk_clk); #1;
    abort     = 1'b0;
    adc_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  // Expected transfer k carries base + k, plus gap once k reaches gap_at.
  task automatic check_xfers(input string tag, input int n, input int base,
                             input int gap_at, input int gap);
    int m;
    check_val({tag, "_count"}, 32'(xd.size()), 32'(n));
    m = (xd.size() < n) ? xd.size() : n;
    for (int k = 0; k < m; k++) begin
      check_val({tag, "_data"}, xd[k], 32'(base + k + ((k >= gap_at) ? gap : 0)));
      check_val({tag, "_sop"}, 32'(xs[k]), 32'((k % FL) == 0));
      check_val({tag, "_eop"}, 32'(xe[k]), 32'((k % FL) == FL - 1));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, "_data"}, 32'(out_data), 32'd0);
    check_val({tag, "_sop"}, 32'(out_startofpacket), 32'd0);
    check_val({tag, "_eop"}, 32'(out_endofpacket), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_ovf"}, 32'(overflow), 32'd0);
    check_val({tag, "_fsent"}, 32'(frames_sent), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk_clk);
    #1;
    check_idle_outputs("rst");
    reset_reset_n = 1'b1;

    // Two clean frames: ramp 0..15, done one cycle after the final transfer.
    run_stream(2, 0, 0, 0, -1, 30);
    check_xfers("t1", 16, 0, 16, 0);
    check_val("t1_done_cnt", 32'(done_cnt), 32'd1);
    check_val("t1_done_lat", 32'(done_cyc - last_xfer_cyc), 32'd1);
    check_val("t1_fsent", 32'(frames_sent), 32'd2);
    check_val("t1_ovf", 32'(overflow), 32'd0);
    check_val("t1_busy", 32'(busy), 32'd0);

    // Four-cycle stall mid-frame: peak occupancy 5, nothing lost.
    run_stream(2, 0, 5, 4, -1, 30);
    check_xfers("t2", 16, 0, 16, 0);
    check_val("t2_ovf", 32'(overflow), 32'd0);
    check_val("t2_fsent", 32'(frames_sent), 32'd2);
    check_val("t2_done_cnt", 32'(done_cnt), 32'd1);

    // Ready low from the first sample for 11 cycles: samples 0..7 fill the
    // buffer, 8..10 arrive full, and 11 arrives on the resume cycle while still
    // full before the pop, so four samples (8..11) are lost.
    run_stream(2, 0, 1, 11, -1, 40);
    check_xfers("t3", 16, 0, 8, 4);
    check_val("t3_ovf", 32'(overflow), 32'd1);
    check_val("t3_fsent", 32'(frames_sent), 32'd2);
    check_val("t3_done_cnt", 32'(done_cnt), 32'd1);

    // Abort coinciding with the third beat of the first frame.
    run_stream(2, 0, 0, 0, 4, 4);
    check_val("t4_valid", 32'(out_valid), 32'd0);
    check_val("t4_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk_clk);
    #1;
    check_val("t4_count", 32'(xd.size()), 32'd3);
    check_val("t4_done_cnt", 32'(done_cnt), 32'd0);
    check_val("t4_fsent", 32'(frames_sent), 32'd0);

    // Zero-frame start: done pulse next cycle, no stream.
    xd.delete();
    done_cnt = 0;
    @(posedge clk_clk); #1;
    start      = 1'b1;
    num_frames = '0;
    @(posedge clk_clk); #1;
    start     = 1'b0;
    adc_valid = 1'b1;
    check_val("t5_done", 32'(done), 32'd1);
    check_val("t5_busy", 32'(busy), 32'd0);
    @(posedge clk_clk); #1;
    check_val("t5_done_off", 32'(done), 32'd0);
    repeat (6) @(posedge clk_clk);
    #1;
    adc_valid = 1'b0;
    check_val("t5_no_xfer", 32'(xd.size()), 32'd0);
    check_val("t5_done_cnt", 32'(done_cnt), 32'd1);

    // Abort and start together in IDLE: abort wins, nothing starts.
    @(posedge clk_clk); #1;
    start      = 1'b1;
    abort      = 1'b1;
    num_frames = FW'(2);
    @(posedge clk_clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check_val("t5b_busy", 32'(busy), 32'd0);

    // Reset mid-stream, then a fresh one-frame run starting at sample 100.
    run_stream(2, 50, 0, 0, -1, 6);
    check_val("t6_busy_pre", 32'(busy), 32'd1);
    reset_reset_n = 1'b0;
    #2;
    check_idle_outputs("t6_rst");
    repeat (2) @(posedge clk_clk);
    #1;
    check_idle_outputs("t6_rst_hold");
    reset_reset_n = 1'b1;
    run_stream(1, 100, 0, 0, -1, 20);
    check_xfers("t6", 8, 100, 8, 0);
    check_val("t6_done_cnt", 32'(done_cnt), 32'd1);
    check_val("t6_fsent", 32'(frames_sent), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
